dsm_result_packer: RTL and testbench

- Downstream stage of the multichannel digital signal measurement block.
- Captures each channel's 16-bit results (high, low, period, duty) when that channel's measure_done rises.
- Queues pending channels and serialises them, round-robin, into fixed-format byte frames on a valid/ready byte stream.
- Feeds the host upload path (UART/USB TX FIFO).

---
 rtl/dsm_pkg.sv | 44 ++++
 rtl/dsm_result_packer_if.sv | 27 ++
 rtl/dsm_rr_arbiter.sv | 35 +++
 rtl/dsm_result_packer.sv | 156 +++++++++++++++
 tb/tb_dsm_result_packer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsm_pkg.sv
// Shared types and constants for the measurement result packer.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
// Contents: frame header default, base frame length, FSM state enum,
// per-channel result struct and (checksum build) the frame checksum helper.
// Optional feature macro: DSM_PACKER_CHECKSUM_EN (adds a trailing sum byte).
package dsm_pkg;

  localparam logic [7:0] FRAME_HEADER_DEFAULT = 8'hAA;
  localparam int         FRAME_LEN_BASE       = 10;

`ifdef DSM_PACKER_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_BASE + 1;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } packer_state_t;

  typedef struct packed {
    logic [15:0] high;
    logic [15:0] low;
    logic [15:0] period;
    logic [15:0] duty;
  } dsm_result_t;

`ifdef DSM_PACKER_CHECKSUM_EN
  // Modulo-256 sum of every frame byte after the header.
  function automatic logic [7:0] frame_sum(input logic [7:0] ch_byte,
                                           input dsm_result_t r);
    logic [7:0] s;
    s = ch_byte;
    s = s + r.high[15:8]   + r.high[7:0];
    s = s + r.low[15:8]    + r.low[7:0];
    s = s + r.period[15:8] + r.period[7:0];
    s = s + r.duty[15:8]   + r.duty[7:0];
    return s;
  endfunction
`endif

endpackage

// File: rtl/dsm_result_packer_if.sv
// Byte-stream interface carrying packed result frames to the host upload path.
// Latency: n/a (wires only).
// Backpressure: a byte transfers when tx_valid && tx_ready; master holds data while stalled.
// Signals: tx_data (frame byte), tx_valid, tx_last (final byte of frame), tx_ready.
// Modports: master = packer side, slave = consumer (TX FIFO) side.
interface dsm_result_packer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );

endinterface

// File: rtl/dsm_rr_arbiter.sv
// Round-robin request picker: first set request searching from ptr+1 with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when a grant is taken.
// Ports: req (request vector), ptr (last served index),
//        grant_oh (one-hot grant), grant_idx (grant index), any (some request set).
module dsm_rr_arbiter #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant_oh,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int W = $clog2(N);

  always_comb begin
    int idx;
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    // Offsets 1..N visit every channel once, the last served one last.
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[idx]) begin
        any           = 1'b1;
        grant_idx     = W'(idx);
        grant_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsm_result_packer.sv
// Captures per-channel measurement results on measure_done rising and emits them as byte frames.
// Latency: event sampled at edge T, grant at T+1, header byte valid in the cycle after T+1.
// Backpressure: byte held stable while tx_ready low; new results wait in pending, older unsent data is overwritten and flagged.
// Ports: clk, rst (sync, active-high); measure_done[N]; high/low/period/duty_time
//        (flattened N*16, ch at [ch*16 +: 16]); tx (byte stream master);
//        busy; overrun[N] (sticky); overrun_clr.
// Optional feature macro: DSM_PACKER_CHECKSUM_EN appends a sum byte (frame 11 bytes, else 10).
module dsm_result_packer
  import dsm_pkg::*;
#(
  parameter int         NUM_CHANNELS = 8,
  parameter logic [7:0] FRAME_HEADER = FRAME_HEADER_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CHANNELS-1:0]    measure_done,
  input  logic [NUM_CHANNELS*16-1:0] high_time,
  input  logic [NUM_CHANNELS*16-1:0] low_time,
  input  logic [NUM_CHANNELS*16-1:0] period_time,
  input  logic [NUM_CHANNELS*16-1:0] duty_cycle,
  dsm_result_packer_if.master        tx,
  output logic                       busy,
  output logic [NUM_CHANNELS-1:0]    overrun,
  input  logic                       overrun_clr
);

  localparam int PTR_W = $clog2(NUM_CHANNELS);

  packer_state_t         state, state_nxt;
  logic [NUM_CHANNELS-1:0] done_q;
  logic [NUM_CHANNELS-1:0] evt;
  logic [NUM_CHANNELS-1:0] pending;
  dsm_result_t           shadow [NUM_CHANNELS];
  dsm_result_t           frame;
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      ch_idx;
  logic [3:0]            byte_idx;
  logic [NUM_CHANNELS-1:0] grant_oh;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  grant_fire;
  logic                  byte_acc;
  logic                  last_byte;
  logic [7:0]            ch_byte;
  logic [7:0]            byte_dat;

  assign evt = measure_done & ~done_q;

  dsm_rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
    .req       (pending),
    .ptr       (ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign last_byte = (byte_idx == 4'(FRAME_LEN - 1));
  assign byte_acc  = (state == SEND) && tx.tx_ready;

  // Next-state and grant decision.
  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          grant_fire = 1'b1;
          state_nxt  = SEND;
        end
      end
      SEND: begin
        if (byte_acc && last_byte) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture, pending and overrun bookkeeping per channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q  <= '1;  // a level already high at reset release is not an event
      pending <= '0;
      overrun <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) shadow[ch] <= '0;
    end else begin
      done_q <= measure_done;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        // A fresh event beats the grant's clear: the granted frame takes the
        // old snapshot and the new one stays queued without an overrun.
        if (evt[ch]) begin
          shadow[ch]  <= {high_time[ch*16 +: 16], low_time[ch*16 +: 16],
                          period_time[ch*16 +: 16], duty_cycle[ch*16 +: 16]};
          pending[ch] <= 1'b1;
        end else if (grant_fire && grant_oh[ch]) begin
          pending[ch] <= 1'b0;
        end
        // Set has priority over clear.
        if (evt[ch] && pending[ch] && !(grant_fire && grant_oh[ch]))
          overrun[ch] <= 1'b1;
        else if (overrun_clr)
          overrun[ch] <= 1'b0;
      end
    end
  end

  // Frame load on grant and byte stepping on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame    <= '0;
      ch_idx   <= '0;
      ptr      <= PTR_W'(NUM_CHANNELS - 1);  // channel 0 searched first
      byte_idx <= '0;
    end else if (grant_fire) begin
      frame    <= shadow[grant_idx];
      ch_idx   <= grant_idx;
      ptr      <= grant_idx;
      byte_idx <= '0;
    end else if (byte_acc && !last_byte) begin
      byte_idx <= byte_idx + 4'd1;
    end
  end

  assign ch_byte = 8'(ch_idx);

  always_comb begin
    byte_dat = 8'h00;
    case (byte_idx)
      4'd0:    byte_dat = FRAME_HEADER;
      4'd1:    byte_dat = ch_byte;
      4'd2:    byte_dat = frame.high[15:8];
      4'd3:    byte_dat = frame.high[7:0];
      4'd4:    byte_dat = frame.low[15:8];
      4'd5:    byte_dat = frame.low[7:0];
      4'd6:    byte_dat = frame.period[15:8];
      4'd7:    byte_dat = frame.period[7:0];
      4'd8:    byte_dat = frame.duty[15:8];
      4'd9:    byte_dat = frame.duty[7:0];
`ifdef DSM_PACKER_CHECKSUM_EN
      4'd10:   byte_dat = frame_sum(ch_byte, frame);
`endif
      default: byte_dat = 8'h00;
    endcase
  end

  assign tx.tx_valid = (state == SEND);
  assign tx.tx_last  = (state == SEND) && last_byte;
  assign tx.tx_data  = (state == SEND) ? byte_dat : 8'h00;

  assign busy = (state != IDLE) || (|pending);

endmodule

// File: tb/tb_dsm_result_packer.sv
// Self-checking bench for dsm_result_packer: scoreboard of expected frame bytes.
// Latency: n/a.  Backpressure: driven by the bench through tx_ready.
module tb_dsm_result_packer;

  localparam int N = 8;
`ifdef DSM_PACKER_CHECKSUM_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    measure_done;
  logic [N*16-1:0] high_time, low_time, period_time, duty_cycle;
  logic            busy;
  logic [N-1:0]    overrun;
  logic            overrun_clr;

  always #5 clk = ~clk;

  dsm_result_packer_if tx_if ();

  dsm_result_packer #(.NUM_CHANNELS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .measure_done (measure_done),
    .high_time    (high_time),
    .low_time     (low_time),
    .period_time  (period_time),
    .duty_cycle   (duty_cycle),
    .tx           (tx_if),
    .busy         (busy),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  typedef struct {
    logic [7:0] dat;
    logic       last;
  } exp_t;

  exp_t exp_q [$];
  exp_t exp_e;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   vld_cnt = 0;
  int   acc_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat   = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int ch, input logic [15:0] h, input logic [15:0] l,
                            input logic [15:0] p, input logic [15:0] d);
    logic [7:0] b [11];
    logic [7:0] sum;
    b[0] = 8'hAA;      b[1] = 8'(ch);
    b[2] = h[15:8];    b[3] = h[7:0];
    b[4] = l[15:8];    b[5] = l[7:0];
    b[6] = p[15:8];    b[7] = p[7:0];
    b[8] = d[15:8];    b[9] = d[7:0];
    sum = 8'h00;
    for (int i = 1; i < 10; i++) sum = sum + b[i];
    b[10] = sum;
    for (int i = 0; i < FLEN; i++) exp_q.push_back('{dat: b[i], last: (i == FLEN - 1)});
  endtask

  // Output monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (tx_if.tx_valid) vld_cnt++;
    if (prev_stall && tx_if.tx_valid) check("hold_dat", tx_if.tx_data, prev_dat);
    if (tx_if.tx_valid && tx_if.tx_ready) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        check("sb_empty", exp_q.size(), 1);
      end else begin
        exp_e = exp_q.pop_front();
        check("byte", tx_if.tx_data, exp_e.dat);
        check("last", tx_if.tx_last, exp_e.last);
      end
    end
    prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
    prev_dat   = tx_if.tx_data;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ch(input int ch, input logic [15:0] h, input logic [15:0] l,
                        input logic [15:0] p, input logic [15:0] d);
    high_time[ch*16 +: 16]   = h;
    low_time[ch*16 +: 16]    = l;
    period_time[ch*16 +: 16] = p;
    duty_cycle[ch*16 +: 16]  = d;
  endtask

  task automatic fire(input logic [N-1:0] m);
    measure_done = measure_done | m;
    tick(1);
    measure_done = measure_done & ~m;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!tx_if.tx_valid && n < 50) begin
      tick(1);
      n++;
    end
    if (!tx_if.tx_valid) check("wait_valid_timeout", tx_if.tx_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (!(exp_q.size() == 0 && !tx_if.tx_valid && !busy) && n < 600) begin
      tick(1);
      n++;
    end
    if (n >= 600) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst = 1'b1; measure_done = '0; overrun_clr = 1'b0; tx_if.tx_ready = 1'b1;
    high_time = '0; low_time = '0; period_time = '0; duty_cycle = '0;
    tick(3);
    check("rst_valid",   tx_if.tx_valid, 0);
    check("rst_last",    tx_if.tx_last, 0);
    check("rst_data",    tx_if.tx_data, 0);
    check("rst_busy",    busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick(2);

    // Simultaneous ch0/ch5 right after reset: ch0 first. Also checks latency.
    set_ch(0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    set_ch(5, 16'hA5A5, 16'h0F0F, 16'h1234, 16'hFEDC);
    push_frame(0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    push_frame(5, 16'hA5A5, 16'h0F0F, 16'h1234, 16'hFEDC);
    fire(8'h21);
    check("lat_not_yet", tx_if.tx_valid, 0);
    check("busy_pending", busy, 1);
    tick(1);
    check("lat_valid", tx_if.tx_valid, 1);
    check("lat_header", tx_if.tx_data, 8'hAA);
    drain();

    // ptr=5: ch0 and ch3 together; search 6,7,0 wraps to ch0 first, then ch3.
    set_ch(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    set_ch(3, 16'hBEEF, 16'hCAFE, 16'h0100, 16'h0080);
    push_frame(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    push_frame(3, 16'hBEEF, 16'hCAFE, 16'h0100, 16'h0080);
    fire(8'h09);
    drain();

    // ptr=3: ch1 and ch4 together; ch4 precedes ch1.
    set_ch(1, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
    set_ch(4, 16'h4040, 16'h5050, 16'h6060, 16'h7070);
    push_frame(4, 16'h4040, 16'h5050, 16'h6060, 16'h7070);
    push_frame(1, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
    fire(8'h12);
    drain();

    // Single channel reference frame.
    set_ch(2, 16'h0010, 16'h0030, 16'h0040, 16'h0190);
    push_frame(2, 16'h0010, 16'h0030, 16'h0040, 16'h0190);
    fire(8'h04);
    drain();

    // Backpressure: ready toggles every cycle, starting low on the first valid cycle.
    tx_if.tx_ready = 1'b0;
    set_ch(7, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA);
    push_frame(7, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA);
    base = vld_cnt;
    fire(8'h80);
    wait_valid();
    n = 0;
    while (!(exp_q.size() == 0 && !tx_if.tx_valid) && n < 100) begin
      @(posedge clk);
      #1;
      tx_if.tx_ready = ~tx_if.tx_ready;
      n++;
    end
    check("bp_valid_cycles", vld_cnt - base, 2 * FLEN);
    tx_if.tx_ready = 1'b1;
    drain();

    // Overrun: ch1 fires twice while a ch0 frame is stalled.
    tx_if.tx_ready = 1'b0;
    set_ch(0, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
    push_frame(0, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
    fire(8'h01);
    wait_valid();
    set_ch(1, 16'h1000, 16'h2000, 16'h3000, 16'h4000);
    fire(8'h02);
    tick(1);
    check("ovr_first_evt", overrun, 8'h00);
    set_ch(1, 16'h1001, 16'h2002, 16'h3003, 16'h4004);
    fire(8'h02);
    tick(1);
    check("ovr_set", overrun, 8'h02);
    check("busy_stall", busy, 1);
    push_frame(1, 16'h1001, 16'h2002, 16'h3003, 16'h4004);
    tx_if.tx_ready = 1'b1;
    drain();
    check("ovr_sticky", overrun, 8'h02);
    overrun_clr = 1'b1;
    tick(1);
    overrun_clr = 1'b0;
    check("ovr_clr", overrun, 8'h00);

    // Same-cycle event and grant on ch3.
    tx_if.tx_ready = 1'b0;
    set_ch(0, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
    push_frame(0, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
    fire(8'h01);
    wait_valid();
    set_ch(3, 16'h0303, 16'h0033, 16'h3300, 16'h3030);
    push_frame(3, 16'h0303, 16'h0033, 16'h3300, 16'h3030);
    fire(8'h08);
    tx_if.tx_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_if.tx_valid && tx_if.tx_last && tx_if.tx_ready) && n < 100);
    if (n >= 100) check("last_timeout", tx_if.tx_last, 1);
    @(posedge clk);  // last byte of the ch0 frame accepted here
    #1;
    set_ch(3, 16'hF00D, 16'hD00F, 16'h0BAD, 16'hC0DE);
    push_frame(3, 16'hF00D, 16'hD00F, 16'h0BAD, 16'hC0DE);
    fire(8'h08);   // sampled on the same edge that grants ch3
    drain();
    check("same_cycle_ovr", overrun, 8'h00);

    // Reset in the middle of a frame, with measure_done held high across it.
    set_ch(6, 16'h6161, 16'h6262, 16'h6363, 16'h6464);
    push_frame(6, 16'h6161, 16'h6262, 16'h6363, 16'h6464);
    base = acc_cnt;
    measure_done[6] = 1'b1;
    n = 0;
    while (acc_cnt < base + 4 && n < 50) begin
      tick(1);
      n++;
    end
    check("rst_mid_bytes", acc_cnt - base, 4);
    rst = 1'b1;
    tick(1);
    check("rst_mid_valid", tx_if.tx_valid, 0);
    check("rst_mid_busy", busy, 0);
    rst = 1'b0;
    exp_q.delete();
    base = vld_cnt;
    tick(20);
    check("held_level_no_frame", vld_cnt - base, 0);
    check("held_level_busy", busy, 0);
    measure_done[6] = 1'b0;
    tick(1);
    push_frame(6, 16'h6161, 16'h6262, 16'h6363, 16'h6464);
    fire(8'h40);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
